uart_tx_arbiter: RTL and testbench

//  Round-robin scheduler sharing one uart_tx transmitter between NUM_REQ byte producers.

---
 rtl/uart_tx_arbiter_if.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 147 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Producer/transmitter-side bundle for uart_tx_arbiter.
// slave = the arbiter itself, master = producers plus the uart_tx status lines.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int OW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   Req;
    logic [NUM_REQ-1:0]   Lock;
    logic [8*NUM_REQ-1:0] Req_Byte;
    logic [NUM_REQ-1:0]   Ack;
    logic [NUM_REQ-1:0]   Sent;
    logic [OW-1:0]        Owner;
    logic                 Busy;
    logic                 Err;
    logic                 Tx_Start;
    logic [7:0]           Tx_Byte;
    logic                 Tx_Active;
    logic                 Tx_Done;

    modport master (
        output Req, Lock, Req_Byte, Tx_Active, Tx_Done,
        input  Ack, Sent, Owner, Busy, Err, Tx_Start, Tx_Byte
    );

    modport slave (
        input  Req, Lock, Req_Byte, Tx_Active, Tx_Done,
        output Ack, Sent, Owner, Busy, Err, Tx_Start, Tx_Byte
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx between NUM_REQ byte producers, with per-requester lock.
// Optional transmit watchdog enabled by defining UART_ARB_WATCHDOG_EN.
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int GAP_CYCLES  = 1,
    parameter int WDOG_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int OW = $clog2(NUM_REQ);
    localparam logic [7:0] GAP_LD = 8'(GAP_CYCLES);

    typedef enum logic [1:0] {IDLE, WAIT_DONE, GAP} state_t;

    state_t               state_q;
    logic [OW-1:0]        owner_q;
    logic                 lock_held_q;
    logic [7:0]           gap_q;
    logic [7:0]           tx_byte_q;
    logic [NUM_REQ-1:0]   ack_q;
    logic [NUM_REQ-1:0]   sent_q;
    logic                 tx_start_q;
    logic                 busy_q;

    logic [OW-1:0]        cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0]   cand_req;
    logic [7:0]           byte_arr [NUM_REQ];
    logic [OW-1:0]        rr_idx;
    logic [OW-1:0]        win_idx;
    logic                 grant;
    logic                 wdog_hit;

    // Candidates in priority order: Owner+1, Owner+2, ..., Owner itself last.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
            logic [OW:0] sum;
            assign sum          = {1'b0, owner_q} + (OW+1)'(gi + 1);
            assign cand_idx[gi] = (sum >= (OW+1)'(NUM_REQ)) ? OW'(sum - (OW+1)'(NUM_REQ)) : OW'(sum);
            assign cand_req[gi] = bus.Req[cand_idx[gi]];
            assign byte_arr[gi] = bus.Req_Byte[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        rr_idx = owner_q;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (cand_req[k]) rr_idx = cand_idx[k];
        end
        win_idx = (lock_held_q && bus.Req[owner_q]) ? owner_q : rr_idx;
        grant   = (|bus.Req) && !bus.Tx_Active;
    end

`ifdef UART_ARB_WATCHDOG_EN
    logic [15:0] wdog_q;
    logic        err_q;
    assign wdog_hit = (wdog_q == 16'(WDOG_CYCLES - 1));
    assign bus.Err  = err_q;
`else
    assign wdog_hit = 1'b0;
    assign bus.Err  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OW'(NUM_REQ - 1);
            lock_held_q <= 1'b0;
            gap_q       <= 8'd0;
            tx_byte_q   <= 8'd0;
            ack_q       <= '0;
            sent_q      <= '0;
            tx_start_q  <= 1'b0;
            busy_q      <= 1'b0;
`ifdef UART_ARB_WATCHDOG_EN
            wdog_q      <= 16'd0;
            err_q       <= 1'b0;
`endif
        end else begin
            ack_q      <= '0;
            sent_q     <= '0;
            tx_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // A locked owner that stopped requesting gives up its claim.
                    if (lock_held_q && !bus.Req[owner_q]) lock_held_q <= 1'b0;
                    if (grant) begin
                        owner_q         <= win_idx;
                        tx_byte_q       <= byte_arr[win_idx];
                        ack_q[win_idx]  <= 1'b1;
                        tx_start_q      <= 1'b1;
                        busy_q          <= 1'b1;
                        state_q         <= WAIT_DONE;
`ifdef UART_ARB_WATCHDOG_EN
                        wdog_q          <= 16'd0;
`endif
                    end
                end
                WAIT_DONE: begin
                    if (bus.Tx_Done || wdog_hit) begin
                        if (GAP_CYCLES == 0) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= GAP;
                            gap_q   <= GAP_LD;
                        end
                    end
                    if (bus.Tx_Done) begin
                        sent_q[owner_q] <= 1'b1;
                        lock_held_q     <= bus.Lock[owner_q];
                    end
`ifdef UART_ARB_WATCHDOG_EN
                    else if (wdog_hit) begin
                        err_q       <= 1'b1;
                        lock_held_q <= 1'b0;
                    end else begin
                        wdog_q <= wdog_q + 16'd1;
                    end
`endif
                end
                GAP: begin
                    if (gap_q <= 8'd1) begin
                        gap_q   <= 8'd0;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        gap_q <= gap_q - 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Ack      = ack_q;
    assign bus.Sent     = sent_q;
    assign bus.Owner    = owner_q;
    assign bus.Busy     = busy_q;
    assign bus.Tx_Start = tx_start_q;
    assign bus.Tx_Byte  = tx_byte_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a behavioural uart_tx (4 clocks per bit).
// Define UART_ARB_WATCHDOG_EN for both RTL and bench to exercise the watchdog.
module tb_uart_tx_arbiter;
    localparam int NREQ = 4;
    localparam int GAP  = 1;
    localparam int CPB  = 4;
    localparam int WDOG = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    uart_tx_arbiter_if #(.NUM_REQ(NREQ)) bus ();

    uart_tx_arbiter #(.NUM_REQ(NREQ), .GAP_CYCLES(GAP), .WDOG_CYCLES(WDOG)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural uart_tx: no reset, frame = start, 8 data LSB-first, stop.
    logic       m_active = 1'b0;
    logic       m_done   = 1'b0;
    logic       m_serial = 1'b1;
    logic [9:0] m_shift  = 10'h3FF;
    int         m_bit    = 0;
    int         m_clk    = 0;
    logic       done_en  = 1'b1;

    always @(posedge clk) begin
        m_done <= 1'b0;
        if (!m_active) begin
            if (bus.Tx_Start) begin
                m_active <= 1'b1;
                m_shift  <= {1'b1, bus.Tx_Byte, 1'b0};
                m_bit    <= 0;
                m_clk    <= 0;
                m_serial <= 1'b0;
            end
        end else if (m_clk == CPB - 1) begin
            m_clk <= 0;
            if (m_bit == 9) begin
                m_active <= 1'b0;
                m_done   <= 1'b1;
                m_serial <= 1'b1;
            end else begin
                m_bit    <= m_bit + 1;
                m_serial <= m_shift[m_bit+1];
            end
        end else begin
            m_clk <= m_clk + 1;
        end
    end

    assign bus.Tx_Active = m_active;
    assign bus.Tx_Done   = m_done & done_en;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_ack(input int limit, output logic [3:0] ack, output bit ok);
        ok  = 1'b0;
        ack = '0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (bus.Ack != '0) begin
                ack = bus.Ack;
                ok  = 1'b1;
                $display("grant: Ack=%b Owner=%0d Tx_Byte=%h cycle %0d", bus.Ack, bus.Owner, bus.Tx_Byte, cyc);
                break;
            end
        end
    endtask

    task automatic wait_done(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (bus.Tx_Done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!m_active && !bus.Busy) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL drain: still busy/active, required idle"); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        bus.Req = '0; bus.Lock = '0; bus.Req_Byte = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks += 7;
        if (bus.Ack !== 4'b0)      begin n_fail++; $display("FAIL reset_ack: got %b required 0000", bus.Ack); end
        if (bus.Sent !== 4'b0)     begin n_fail++; $display("FAIL reset_sent: got %b required 0000", bus.Sent); end
        if (bus.Tx_Start !== 1'b0) begin n_fail++; $display("FAIL reset_txstart: got %b required 0", bus.Tx_Start); end
        if (bus.Busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %b required 0", bus.Busy); end
        if (bus.Err !== 1'b0)      begin n_fail++; $display("FAIL reset_err: got %b required 0", bus.Err); end
        if (bus.Tx_Byte !== 8'h00) begin n_fail++; $display("FAIL reset_txbyte: got %h required 00", bus.Tx_Byte); end
        if (bus.Owner !== 2'd3)    begin n_fail++; $display("FAIL reset_owner: got %0d required 3", bus.Owner); end
    endtask

    task automatic test_single();
        logic [9:0] frame = '0;
        logic [9:0] want = {1'b1, 8'hA5, 1'b0};
        bit ok;
        bus.Req_Byte = {24'h0, 8'hA5};
        bus.Req = 4'b0001;
        @(negedge clk);
        n_checks += 5;
        if (bus.Ack !== 4'b0001)   begin n_fail++; $display("FAIL single_ack_latency: got %b required 0001", bus.Ack); end
        if (bus.Tx_Start !== 1'b1) begin n_fail++; $display("FAIL single_txstart: got %b required 1", bus.Tx_Start); end
        if (bus.Tx_Byte !== 8'hA5) begin n_fail++; $display("FAIL single_txbyte: got %h required a5", bus.Tx_Byte); end
        if (bus.Owner !== 2'd0)    begin n_fail++; $display("FAIL single_owner: got %0d required 0", bus.Owner); end
        if (bus.Busy !== 1'b1)     begin n_fail++; $display("FAIL single_busy: got %b required 1", bus.Busy); end
        $display("grant: Ack=%b Owner=%0d Tx_Byte=%h cycle %0d", bus.Ack, bus.Owner, bus.Tx_Byte, cyc);
        bus.Req = '0;
        @(negedge clk);
        n_checks += 2;
        if (bus.Tx_Start !== 1'b0) begin n_fail++; $display("FAIL single_txstart_pulse: got %b required 0", bus.Tx_Start); end
        if (bus.Ack !== 4'b0)      begin n_fail++; $display("FAIL single_ack_pulse: got %b required 0000", bus.Ack); end
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            frame[i] = m_serial;
            if (i < 9) repeat (CPB) @(negedge clk);
        end
        n_checks++;
        if (frame !== want) begin n_fail++; $display("FAIL single_serial: got %b required %b", frame, want); end
        wait_done(100, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL single_done_timeout: got none required Tx_Done"); end
        @(negedge clk);
        n_checks++;
        if (bus.Sent !== 4'b0001) begin n_fail++; $display("FAIL single_sent: got %b required 0001", bus.Sent); end
        drain();
    endtask

    // Plays a fixed grant order; lock_drop_after >= 0 clears Lock after that many grants.
    task automatic run_sequence(input string name, input logic [3:0] req, input logic [3:0] lock,
                                input int exp_seq [5], input int lock_drop_after);
        logic [3:0] a;
        bit ok;
        do_reset();
        bus.Req_Byte = {8'h4D, 8'h3C, 8'h2B, 8'h1A};
        bus.Lock = lock;
        bus.Req = req;
        for (int t = 0; t < 5; t++) begin
            logic [7:0] eb;
            wait_ack(200, a, ok);
            eb = 8'h1A + 8'(8'h11 * exp_seq[t]);
            n_checks += 3;
            if (!ok) begin n_fail++; $display("FAIL %s_timeout: no Ack at grant %0d, required requester %0d", name, t, exp_seq[t]); n_checks -= 2; break; end
            if (a !== 4'(1 << exp_seq[t])) begin n_fail++; $display("FAIL %s_ack: grant %0d got %b required %b", name, t, a, 4'(1 << exp_seq[t])); end
            if (bus.Owner !== 2'(exp_seq[t])) begin n_fail++; $display("FAIL %s_owner: grant %0d got %0d required %0d", name, t, bus.Owner, exp_seq[t]); end
            if (bus.Tx_Byte !== eb) begin n_fail++; $display("FAIL %s_byte: grant %0d got %h required %h", name, t, bus.Tx_Byte, eb); end
            if (t == lock_drop_after) bus.Lock = '0;
            if (t == 4) bus.Req = '0;
        end
        drain();
    endtask

    task automatic test_round_robin();
        int s [5] = '{0, 1, 2, 3, 0};
        run_sequence("rr", 4'b1111, 4'b0000, s, -1);
    endtask

    task automatic test_lock();
        int s [5] = '{0, 0, 0, 1, 0};
        run_sequence("lock", 4'b0011, 4'b0001, s, 2);
    endtask

    task automatic test_wrap();
        int s [5] = '{0, 3, 0, 3, 0};
        run_sequence("wrap", 4'b1001, 4'b0000, s, -1);
    endtask

    task automatic test_reset_midframe();
        logic [3:0] a;
        bit ok;
        bit bad = 1'b0;
        bit seen_idle = 1'b0;
        do_reset();
        bus.Req_Byte = {8'h00, 8'h00, 8'h3C, 8'h00};
        bus.Req = 4'b0010;
        wait_ack(20, a, ok);
        n_checks++;
        if (a !== 4'b0010) begin n_fail++; $display("FAIL midrst_first_ack: got %b required 0010", a); end
        repeat (16) @(negedge clk);
        do_reset();
        n_checks += 3;
        if (bus.Owner !== 2'd3) begin n_fail++; $display("FAIL midrst_owner: got %0d required 3", bus.Owner); end
        if (bus.Busy !== 1'b0)  begin n_fail++; $display("FAIL midrst_busy: got %b required 0", bus.Busy); end
        if (m_active !== 1'b1)  begin n_fail++; $display("FAIL midrst_frame_active: got %b required 1", m_active); end
        for (int i = 0; i < 100; i++) begin
            if (!m_active) begin seen_idle = 1'b1; break; end
            if (bus.Tx_Start || bus.Ack != '0 || bus.Sent != '0) bad = 1'b1;
            @(negedge clk);
        end
        n_checks += 2;
        if (bad) begin n_fail++; $display("FAIL midrst_no_grant: got activity while Tx_Active, required none"); end
        if (!seen_idle) begin n_fail++; $display("FAIL midrst_drain_timeout: got Tx_Active stuck, required fall"); end
        @(negedge clk);
        n_checks += 2;
        if (bus.Ack !== 4'b0010)   begin n_fail++; $display("FAIL midrst_regrant_ack: got %b required 0010", bus.Ack); end
        if (bus.Tx_Start !== 1'b1) begin n_fail++; $display("FAIL midrst_regrant_start: got %b required 1", bus.Tx_Start); end
        bus.Req = '0;
        drain();
    endtask

    task automatic test_stall();
        logic [3:0] a;
        bit ok;
        bit sent_seen = 1'b0;
        do_reset();
        bus.Req_Byte = {8'h00, 8'h5A, 8'h00, 8'h00};
        bus.Req = 4'b0100;
        done_en = 1'b0;
        wait_ack(20, a, ok);
        bus.Req = '0;
        n_checks++;
        if (a !== 4'b0100) begin n_fail++; $display("FAIL stall_ack: got %b required 0100", a); end
`ifdef UART_ARB_WATCHDOG_EN
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.Sent != '0) sent_seen = 1'b1;
        end
        n_checks++;
        if (bus.Err !== 1'b0) begin n_fail++; $display("FAIL wdog_early: got Err=%b required 0", bus.Err); end
        @(negedge clk);
        n_checks++;
        if (bus.Err !== 1'b1) begin n_fail++; $display("FAIL wdog_fire: got Err=%b required 1", bus.Err); end
        bus.Req_Byte = {8'h00, 8'h00, 8'h77, 8'h00};
        bus.Req = 4'b0010;
        wait_ack(200, a, ok);
        bus.Req = '0;
        n_checks += 3;
        if (a !== 4'b0010)    begin n_fail++; $display("FAIL wdog_next_grant: got %b required 0010", a); end
        if (bus.Err !== 1'b1) begin n_fail++; $display("FAIL wdog_sticky: got Err=%b required 1", bus.Err); end
        if (sent_seen)        begin n_fail++; $display("FAIL wdog_sent: got Sent pulse, required none"); end
        done_en = 1'b1;
        drain();
`else
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (bus.Sent != '0) sent_seen = 1'b1;
        end
        n_checks += 3;
        if (bus.Busy !== 1'b1) begin n_fail++; $display("FAIL stall_busy: got %b required 1", bus.Busy); end
        if (bus.Err !== 1'b0)  begin n_fail++; $display("FAIL stall_err: got %b required 0", bus.Err); end
        if (sent_seen)         begin n_fail++; $display("FAIL stall_sent: got Sent pulse, required none"); end
        done_en = 1'b1;
`endif
        do_reset();
        n_checks++;
        if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL stall_reset_busy: got %b required 0", bus.Busy); end
    endtask

    // Reference: Owner keeps the line if it held Lock at its last Tx_Done and still
    // requests; otherwise the next requester after Owner in circular order wins.
    task automatic test_random();
        int         owner_m = NREQ - 1;
        bit         lock_m = 1'b0;
        bit         have_done = 1'b0;
        int         last_done = 0;
        logic [3:0] req_v;
        logic [3:0] lock_v;
        logic [7:0] bytes [NREQ];
        logic [3:0] a;
        bit         ok;
        do_reset();
        req_v  = 4'($urandom_range(1, 15));
        lock_v = 4'($urandom);
        for (int b = 0; b < NREQ; b++) bytes[b] = 8'($urandom);
        bus.Req_Byte = {bytes[3], bytes[2], bytes[1], bytes[0]};
        bus.Lock = lock_v;
        bus.Req  = req_v;
        for (int t = 0; t < 40; t++) begin
            int exp_w = owner_m;
            if (!(lock_m && req_v[owner_m])) begin
                for (int s = 1; s <= NREQ; s++) begin
                    if (req_v[(owner_m + s) % NREQ]) begin exp_w = (owner_m + s) % NREQ; break; end
                end
            end
            wait_ack(300, a, ok);
            n_checks++;
            if (!ok) begin n_fail++; $display("FAIL rand_ack_timeout: txn %0d got none required %0d", t, exp_w); break; end
            n_checks += 4;
            if (a !== 4'(1 << exp_w)) begin n_fail++; $display("FAIL rand_ack: txn %0d got %b required %b", t, a, 4'(1 << exp_w)); end
            if (bus.Owner !== 2'(exp_w)) begin n_fail++; $display("FAIL rand_owner: txn %0d got %0d required %0d", t, bus.Owner, exp_w); end
            if (bus.Tx_Byte !== bytes[exp_w]) begin n_fail++; $display("FAIL rand_byte: txn %0d got %h required %h", t, bus.Tx_Byte, bytes[exp_w]); end
            if (bus.Tx_Start !== 1'b1) begin n_fail++; $display("FAIL rand_start: txn %0d got %b required 1", t, bus.Tx_Start); end
            if (have_done) begin
                n_checks++;
                if (cyc - last_done != GAP + 2) begin n_fail++; $display("FAIL rand_spacing: txn %0d got %0d required %0d", t, cyc - last_done, GAP + 2); end
            end
            owner_m = exp_w;
            for (int r = 0; r < NREQ; r++) begin
                if (r == exp_w) begin
                    req_v[r] = ($urandom_range(0, 3) != 0);
                    bytes[r] = 8'($urandom);
                end else if (!req_v[r] && $urandom_range(0, 3) == 0) begin
                    req_v[r] = 1'b1;
                    bytes[r] = 8'($urandom);
                end else if (req_v[r] && $urandom_range(0, 7) == 0) begin
                    req_v[r] = 1'b0;
                end
            end
            if (req_v == '0) begin
                int r = $urandom_range(0, NREQ - 1);
                req_v[r] = 1'b1;
                bytes[r] = 8'($urandom);
            end
            lock_v = 4'($urandom);
            bus.Req_Byte = {bytes[3], bytes[2], bytes[1], bytes[0]};
            bus.Lock = lock_v;
            bus.Req  = req_v;
            wait_done(100, ok);
            n_checks++;
            if (!ok) begin n_fail++; $display("FAIL rand_done_timeout: txn %0d got none required Tx_Done", t); break; end
            lock_m    = lock_v[owner_m];
            last_done = cyc;
            have_done = 1'b1;
            @(negedge clk);
            n_checks++;
            if (bus.Sent !== 4'(1 << owner_m)) begin n_fail++; $display("FAIL rand_sent: txn %0d got %b required %b", t, bus.Sent, 4'(1 << owner_m)); end
        end
        bus.Req = '0;
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_lock();
        test_wrap();
        test_reset_midframe();
        test_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "global timeout");
    end
endmodule
